// File: rtl/instr_fetch_if.sv
// Fetch-side bundle: instruction memory port, ir handshake and redirect.
// master drives memory requests and ir; slave is memory plus controller.
interface instr_fetch_if #(
  parameter int AW = 16
);
  logic          im_req;
  logic [AW-1:0] im_addr;
  logic          im_rdy;
  logic [31:0]   im_data;
  logic [31:0]   ir;
  logic [AW-1:0] ir_pc;
  logic          ir_valid;
  logic          ir_take;
  logic          br_taken;
  logic [AW-1:0] br_addr;

  modport master (
    output im_req, im_addr,
    output ir, ir_pc, ir_valid,
    input  im_rdy, im_data,
    input  ir_take, br_taken, br_addr
  );

  modport slave (
    input  im_req, im_addr,
    input  ir, ir_pc, ir_valid,
    output im_rdy, im_data,
    output ir_take, br_taken, br_addr
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch: PC, single-outstanding memory reads,
// show-ahead prefetch FIFO feeding ir, branch redirect flush.
module instr_fetch #(
  parameter int            AW       = 16,
  parameter logic [AW-1:0] RESET_PC = '0,
  parameter int            DEPTH    = 2
) (
  input logic          clk,
  input logic          rst_f,
  instr_fetch_if.master bus
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEP = (CW+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DROP
  } state_t;

  state_t        state, state_n;
  logic [AW-1:0] fetch_pc, fetch_pc_n;
  logic [AW-1:0] addr_q, addr_n;
  logic [CW-1:0] count, count_tk;
  logic [CW:0]   cnt_ext;
  logic [PW-1:0] head, tail;
  logic [31:0]   buf_data [DEPTH];
  logic [AW-1:0] buf_pc   [DEPTH];
  logic          pop, push, flush;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign bus.ir_valid = (count != '0);
  assign bus.ir       = bus.ir_valid ? buf_data[head] : 32'h0;
  assign bus.ir_pc    = bus.ir_valid ? buf_pc[head] : '0;
  assign bus.im_req   = (state != IDLE);
  assign bus.im_addr  = addr_q;

  assign flush    = bus.br_taken;
  assign pop      = bus.ir_take & bus.ir_valid;
  assign count_tk = count - CW'(pop);
  assign cnt_ext  = {1'b0, count_tk};

  always_comb begin
    state_n    = state;
    fetch_pc_n = fetch_pc;
    addr_n     = addr_q;
    push       = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.br_taken) begin
          state_n    = REQ;
          addr_n     = bus.br_addr;
          fetch_pc_n = bus.br_addr;
        end else if (cnt_ext < DEP) begin
          state_n = REQ;
          addr_n  = fetch_pc;
        end
      end
      REQ: begin
        if (bus.br_taken) begin
          fetch_pc_n = bus.br_addr;
          if (bus.im_rdy) addr_n = bus.br_addr;
          else state_n = DROP;
        end else if (bus.im_rdy) begin
          push       = 1'b1;
          fetch_pc_n = addr_q + AW'(1);
          // After this push the slot is occupied; chain only if one remains
          if (cnt_ext + (CW+1)'(1) < DEP) addr_n = addr_q + AW'(1);
          else state_n = IDLE;
        end
      end
      DROP: begin
        if (bus.br_taken) fetch_pc_n = bus.br_addr;
        if (bus.im_rdy) begin
          state_n = REQ;
          addr_n  = bus.br_taken ? bus.br_addr : fetch_pc;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_f) begin
    if (rst_f) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      addr_q   <= RESET_PC;
    end else begin
      state    <= state_n;
      fetch_pc <= fetch_pc_n;
      addr_q   <= addr_n;
    end
  end

  always_ff @(posedge clk or posedge rst_f) begin
    if (rst_f) begin
      count <= '0;
      head  <= '0;
      tail  <= '0;
    end else if (flush) begin
      count <= '0;
      head  <= '0;
      tail  <= '0;
    end else begin
      count <= count_tk + CW'(push);
      if (pop) head <= inc(head);
      if (push) tail <= inc(tail);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      buf_data[tail] <= bus.im_data;
      buf_pc[tail]   <= addr_q;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: streaming, backpressure,
// redirects during wait/completion, address wrap, reset mid-transfer.
module tb_instr_fetch;
  localparam int AW = 16;

  logic clk = 1'b0;
  logic rst_f = 1'b1;
  logic mem_on = 1'b1;
  logic force_rdy = 1'b0;
  int   lat = 0;
  int   wcnt = 0;
  int   checks = 0;
  int   errors = 0;

  instr_fetch_if #(.AW(AW)) bus ();

  instr_fetch #(
    .AW(AW),
    .RESET_PC(16'h0000),
    .DEPTH(2)
  ) dut (
    .clk(clk),
    .rst_f(rst_f),
    .bus(bus.master)
  );

  always #5 clk = ~clk;

  // memory model: answers after lat wait cycles, data = 0x1000_0000 + addr
  always @(posedge clk)
    if (!bus.im_req || bus.im_rdy) wcnt <= 0;
    else wcnt <= wcnt + 1;

  assign bus.im_rdy  = mem_on ? (bus.im_req && wcnt >= lat) : force_rdy;
  assign bus.im_data = 32'h1000_0000 + 32'(bus.im_addr);

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset;
    rst_f = 1'b1;
    tick();
    tick();
    rst_f = 1'b0;
  endtask

  initial begin
    bus.ir_take  = 1'b1;
    bus.br_taken = 1'b0;
    bus.br_addr  = '0;

    // 1: reset state, then zero-wait streaming
    tick();
    tick();
    chk("rst_req", 64'(bus.im_req), 64'(0));
    chk("rst_addr", 64'(bus.im_addr), 64'(0));
    chk("rst_valid", 64'(bus.ir_valid), 64'(0));
    chk("rst_ir", 64'(bus.ir), 64'(0));
    chk("rst_pc", 64'(bus.ir_pc), 64'(0));
    rst_f = 1'b0;
    tick();
    chk("s_req0", 64'(bus.im_req), 64'(1));
    chk("s_addr0", 64'(bus.im_addr), 64'(0));
    chk("s_valid0", 64'(bus.ir_valid), 64'(0));
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("s_addr", 64'(bus.im_addr), 64'(i));
      chk("s_valid", 64'(bus.ir_valid), 64'(1));
      chk("s_ir", 64'(bus.ir), 64'(32'h1000_0000 + i - 1));
      chk("s_pc", 64'(bus.ir_pc), 64'(i - 1));
    end

    // 2: backpressure fills exactly DEPTH entries
    bus.ir_take = 1'b0;
    do_reset();
    tick();
    chk("bp_addr0", 64'(bus.im_addr), 64'(0));
    tick();
    chk("bp_addr1", 64'(bus.im_addr), 64'(1));
    chk("bp_req1", 64'(bus.im_req), 64'(1));
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_idle", 64'(bus.im_req), 64'(0));
      chk("bp_ir", 64'(bus.ir), 64'(32'h1000_0000));
    end
    bus.ir_take = 1'b1;
    tick();
    chk("bp_resume_req", 64'(bus.im_req), 64'(1));
    chk("bp_resume_addr", 64'(bus.im_addr), 64'(2));
    chk("bp_next_ir", 64'(bus.ir), 64'(32'h1000_0001));

    // 3: 3-cycle latency, redirect in second wait cycle of addr 1
    lat = 3;
    do_reset();
    for (int i = 0; i < 5; i++) tick();
    chk("lat_addr1", 64'(bus.im_addr), 64'(1));
    chk("lat_pc0", 64'(bus.ir_pc), 64'(0));
    tick();
    bus.br_taken = 1'b1;
    bus.br_addr  = 16'h0040;
    tick();
    bus.br_taken = 1'b0;
    chk("drop_hold_addr", 64'(bus.im_addr), 64'(1));
    chk("drop_req", 64'(bus.im_req), 64'(1));
    tick();
    chk("drop_hold2", 64'(bus.im_addr), 64'(1));
    chk("drop_rdy", 64'(bus.im_rdy), 64'(1));
    tick();
    chk("drop_new_addr", 64'(bus.im_addr), 64'(16'h0040));
    chk("drop_no_stale", 64'(bus.ir_valid), 64'(0));
    for (int i = 0; i < 20 && !bus.ir_valid; i++) tick();
    chk("drop_first_valid", 64'(bus.ir_valid), 64'(1));
    chk("drop_first_pc", 64'(bus.ir_pc), 64'(16'h0040));
    chk("drop_first_ir", 64'(bus.ir), 64'(32'h1000_0040));

    // 4: redirect coincident with im_rdy and ir_take
    mem_on = 1'b0;
    force_rdy = 1'b0;
    bus.ir_take = 1'b0;
    do_reset();
    tick();
    force_rdy = 1'b1;
    tick();
    force_rdy = 1'b0;
    chk("co_one_entry", 64'(bus.ir_valid), 64'(1));
    tick();
    chk("co_addr1", 64'(bus.im_addr), 64'(1));
    force_rdy = 1'b1;
    bus.ir_take = 1'b1;
    bus.br_taken = 1'b1;
    bus.br_addr = 16'h0100;
    tick();
    force_rdy = 1'b0;
    bus.ir_take = 1'b0;
    bus.br_taken = 1'b0;
    chk("co_valid", 64'(bus.ir_valid), 64'(0));
    chk("co_ir", 64'(bus.ir), 64'(0));
    chk("co_addr", 64'(bus.im_addr), 64'(16'h0100));
    chk("co_req", 64'(bus.im_req), 64'(1));
    tick();
    chk("co_still_empty", 64'(bus.ir_valid), 64'(0));
    force_rdy = 1'b1;
    tick();
    chk("co_new_pc", 64'(bus.ir_pc), 64'(16'h0100));
    chk("co_new_ir", 64'(bus.ir), 64'(32'h1000_0100));

    // 5: wrap around 0xFFFF
    mem_on = 1'b1;
    lat = 0;
    bus.ir_take = 1'b1;
    bus.br_taken = 1'b1;
    bus.br_addr = 16'hFFFF;
    tick();
    bus.br_taken = 1'b0;
    chk("wr_addr0", 64'(bus.im_addr), 64'(16'hFFFF));
    chk("wr_empty", 64'(bus.ir_valid), 64'(0));
    tick();
    chk("wr_addr1", 64'(bus.im_addr), 64'(16'h0000));
    chk("wr_pc0", 64'(bus.ir_pc), 64'(16'hFFFF));
    chk("wr_ir0", 64'(bus.ir), 64'(32'h1000_FFFF));
    tick();
    chk("wr_addr2", 64'(bus.im_addr), 64'(16'h0001));
    chk("wr_pc1", 64'(bus.ir_pc), 64'(16'h0000));
    tick();
    chk("wr_pc2", 64'(bus.ir_pc), 64'(16'h0001));

    // 6: reset asserted mid-request at addr 5
    mem_on = 1'b0;
    force_rdy = 1'b0;
    bus.ir_take = 1'b0;
    do_reset();
    tick();
    force_rdy = 1'b1;
    bus.ir_take = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    force_rdy = 1'b0;
    chk("mr_req", 64'(bus.im_req), 64'(1));
    chk("mr_addr5", 64'(bus.im_addr), 64'(5));
    rst_f = 1'b1;
    #1;
    chk("mr_async_req", 64'(bus.im_req), 64'(0));
    chk("mr_async_valid", 64'(bus.ir_valid), 64'(0));
    force_rdy = 1'b1;
    tick();
    chk("mr_held_req", 64'(bus.im_req), 64'(0));
    rst_f = 1'b0;
    tick();
    force_rdy = 1'b0;
    chk("mr_restart_req", 64'(bus.im_req), 64'(1));
    chk("mr_restart_addr", 64'(bus.im_addr), 64'(0));
    chk("mr_restart_valid", 64'(bus.ir_valid), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Producer end of the `ir` interface consumed by `sisc`.
- Holds the fetch program counter and issues word reads to instruction memory over a req/rdy handshake.
- Buffers returned words in a small show-ahead FIFO and presents them as `ir` with a valid/take handshake toward the controller.
- Accepts branch redirects from `ctrl`, which flush buffered and in-flight instructions.

Parameters:
- RESET_PC, 16'h0000, fetch address after reset.
- DEPTH, 2, prefetch buffer entries; legal range 2..8.
- AW, 16, instruction address width; memory is word addressed.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_f  in  1  asynchronous, active-high reset.
- im_req  out  1  registered memory read request.
- im_addr  out  AW  word address; stable while im_req is high.
- im_rdy  in  1  memory completion; im_data is valid in this cycle.
- im_data  in  32  instruction word from memory.
- ir  out  32  instruction at the buffer head; 32'h0 when the buffer is empty.
- ir_pc  out  AW  address of the word on ir; 0 when empty.
- ir_valid  out  1  ir holds a valid instruction.
- ir_take  in  1  controller consumes ir this cycle; ignored when ir_valid=0.
- br_taken  in  1  one-cycle redirect strobe.
- br_addr  in  AW  redirect target; sampled when br_taken=1.

Behaviour:
- Reset (asynchronous, while rst_f=1):
  - im_req=0, im_addr=RESET_PC.
  - Buffer empty: ir=0, ir_pc=0, ir_valid=0.
  - fetch_pc=RESET_PC, FSM=IDLE.
- Memory protocol:
  - One outstanding request at most.
  - Once im_req rises, im_req and im_addr hold until a cycle with im_rdy=1. That edge completes the transfer.
  - im_rdy while im_req=0 is ignored.
- Issue condition `room`: count + (request outstanding) < DEPTH. Count is the buffer occupancy after this cycle's take.
- FSM states:
  - IDLE: im_req=0. If room and no br_taken, next state is REQ with im_addr=fetch_pc.
  - REQ: im_req=1. On im_rdy without br_taken:
    - push {im_data, im_addr}; fetch_pc=im_addr+1 (wraps modulo 2^AW).
    - If room remains after the push, stay in REQ with im_req=1 and im_addr advanced in the same edge. This gives back-to-back throughput of 1 word/cycle with a zero-wait memory.
    - Otherwise go to IDLE.
  - DROP: entered on br_taken while in REQ without im_rdy. im_req stays high at the old address until im_rdy. The returned data is discarded, then next state is REQ with im_addr=fetch_pc (the redirect target).
- Redirect (br_taken=1):
  - Buffer flushed at the edge (count=0, ir_valid=0 next cycle).
  - fetch_pc=br_addr.
  - From IDLE, or REQ with im_rdy in the same cycle: that data is discarded and next state is REQ with im_addr=br_addr.
  - From DROP: stay in DROP and update fetch_pc; the final target wins.
- Buffer:
  - DEPTH-entry circular FIFO; head shown combinationally on ir/ir_pc/ir_valid.
  - ir_take with ir_valid pops the head; the next entry appears the following cycle.
  - Push and pop in the same cycle are allowed. Overflow cannot occur because of the room rule.
- Simultaneous events:
  - br_taken together with ir_take: flush dominates; the taken instruction counts as consumed.
  - br_taken together with im_rdy: data dropped.
- Latency:
  - Reset release to first im_req=1: 1 cycle.
  - im_rdy edge to ir_valid=1: 1 cycle (registered push).
  - br_taken edge to im_req at br_addr: next cycle, unless a request is pending (DROP).
- Reset mid-transfer: all state is cleared immediately. A later im_rdy from the aborted request is ignored because im_req=0.

Test Plan:
- Reset release, zero-wait memory (im_rdy=im_req, im_data=0x1000_0000+addr), ir_take always 1:
  - im_addr sequence 0,1,2,3 on consecutive cycles.
  - ir=0x10000000, 0x10000001, … with ir_pc 0,1,2,… one per cycle after 2 cycles.
- ir_take=0 for 10 cycles, zero-wait memory:
  - Exactly DEPTH=2 words fetched (addr 0,1); im_req=0 thereafter.
  - ir stays 0x10000000 with ir_valid=1.
  - Raising ir_take resumes fetch at addr 2.
- Memory with 3-cycle latency; br_taken with br_addr=0x0040 in the second wait cycle of the request at addr 1:
  - im_addr holds 1 until im_rdy; that data never reaches ir.
  - The next request is at 0x0040; the first valid ir_pc after the redirect is 0x0040.
- br_taken with br_addr=0x0100 in the same cycle as im_rdy and ir_take, buffer holding 1 entry:
  - Next cycle ir_valid=0, ir=0.
  - Next im_addr=0x0100; no stale word is delivered.
- Wrap: br_addr=0xFFFF, zero-wait memory:
  - Fetch addresses 0xFFFF, 0x0000, 0x0001.
  - ir_pc follows the same sequence.
- rst_f pulsed mid-REQ (im_req=1 at addr 5), im_rdy arrives while reset is asserted:
  - ir_valid=0 and im_req=0 immediately.
  - After release, the first im_addr=RESET_PC.
